// File: rtl/lsu_mem_port_if.sv
// Data-memory request/response bus between an LSU port (master) and the memory (slave).
// The memory answers a read combinationally in the same cycle and commits writes at the clock edge.
interface lsu_mem_port_if;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memReqStruct;

  typedef struct packed {
    logic [31:0] rd_data;
    logic        MemWrite;
    logic        MemRead;
    logic        valid;
  } memRespStruct;

  memReqStruct  mem_req;
  memRespStruct mem_resp;

  modport master (output mem_req, input mem_resp);
  modport slave  (input mem_req, output mem_resp);

endinterface

// File: rtl/lsu_mem_port.sv
// In-order load/store initiator: FIFO of ops, head issued to memory, registered tagged result.
// Optional MISALIGN_TRAP_EN: misaligned head ops pop without a memory access and return res_err.
module lsu_mem_port #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_store,
  input  logic [31:0]                in_addr,
  input  logic [31:0]                in_wr_data,
  input  logic [TAG_W-1:0]           in_tag,
  lsu_mem_port_if.master             mem,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_is_store,
  output logic [31:0]                res_data,
  output logic                       res_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             st_q   [DEPTH];
  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      wd_q   [DEPTH];
  logic [TAG_W-1:0] tag_q  [DEPTH];

  logic             enq, issue, mem_access;
  logic             head_st, head_mis;
  logic [31:0]      head_addr, head_wd;
  logic [TAG_W-1:0] head_tag;
  logic             unused_resp;

  assign in_ready = (count != CW'(DEPTH)) && !flush;
  assign enq      = in_valid && in_ready;
  // The result register must be free (or freed this cycle) before the head can go out.
  assign issue    = (count != '0) && !flush && (!res_valid || res_ready);

  assign head_st   = st_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_wd   = wd_q[rd_ptr];
  assign head_tag  = tag_q[rd_ptr];

`ifdef MISALIGN_TRAP_EN
  assign head_mis = (head_addr[1:0] != 2'b00);
`else
  assign head_mis = 1'b0;
`endif

  assign mem_access = issue && !head_mis;

  always_comb begin
    mem.mem_req = '0;
    if (mem_access) begin
      mem.mem_req.valid    = 1'b1;
      mem.mem_req.MemWrite = head_st;
      mem.mem_req.MemRead  = !head_st;
      mem.mem_req.addr     = head_addr;
      mem.mem_req.wr_data  = head_wd;
    end
  end

  assign unused_resp = ^{mem.mem_resp.MemWrite, mem.mem_resp.MemRead, mem.mem_resp.valid};

  always_ff @(posedge clk) begin
    if (enq) begin
      st_q[wr_ptr]   <= in_is_store;
      addr_q[wr_ptr] <= in_addr;
      wd_q[wr_ptr]   <= in_wr_data;
      tag_q[wr_ptr]  <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      res_valid    <= 1'b0;
      res_tag      <= '0;
      res_is_store <= 1'b0;
      res_data     <= '0;
`ifdef MISALIGN_TRAP_EN
      res_err      <= 1'b0;
`endif
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (issue) begin
        rd_ptr       <= rd_ptr + 1'b1;
        res_valid    <= 1'b1;
        res_tag      <= head_tag;
        res_is_store <= head_st;
        res_data     <= (head_st || head_mis) ? '0 : mem.mem_resp.rd_data;
`ifdef MISALIGN_TRAP_EN
        res_err      <= head_mis;
`endif
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      count <= count + CW'(enq) - CW'(issue);
    end
  end

`ifndef MISALIGN_TRAP_EN
  assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: vector table, directed flush/wrap/misalign sequences, random vs. an op-level model.
module tb_lsu_mem_port;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_is_store = 1'b0;
  logic [31:0]      in_addr = '0;
  logic [31:0]      in_wr_data = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [TAG_W-1:0] res_tag;
  logic             res_is_store;
  logic [31:0]      res_data;
  logic             res_err;
  logic [2:0]       count;

  lsu_mem_port_if mif ();

  lsu_mem_port #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_addr(in_addr), .in_wr_data(in_wr_data), .in_tag(in_tag),
    .mem(mif),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
    .res_is_store(res_is_store), .res_data(res_data), .res_err(res_err),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] preload(int i);
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction

  // Word-addressed memory with a combinational read port
  logic [31:0] mem_arr [256];

  always_comb begin
    mif.mem_resp          = '0;
    mif.mem_resp.valid    = mif.mem_req.valid;
    mif.mem_resp.MemRead  = mif.mem_req.MemRead;
    mif.mem_resp.MemWrite = mif.mem_req.MemWrite;
    if (mif.mem_req.MemRead) mif.mem_resp.rd_data = mem_arr[mif.mem_req.addr[9:2]];
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= preload(i);
    end else if (mif.mem_req.MemWrite) begin
      mem_arr[mif.mem_req.addr[9:2]] <= mif.mem_req.wr_data;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Op-level reference: results are predicted in acceptance order against a program-order memory image
  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             st;
    logic [31:0]      data;
    logic             err;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] model_mem [256];
  bit          sb_on = 1'b0;

  task automatic sb_sample();
    exp_t e;
    logic mis;
    if (!sb_on) return;
    chk("req_rw_exclusive", {31'd0, mif.mem_req.MemRead & mif.mem_req.MemWrite}, 32'd0);
    if (in_valid && in_ready) begin
`ifdef MISALIGN_TRAP_EN
      mis = (in_addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      e.tag = in_tag;
      e.st  = in_is_store;
      e.err = mis;
      if (in_is_store) begin
        e.data = '0;
        if (!mis) model_mem[in_addr[9:2]] = in_wr_data;
      end else begin
        e.data = mis ? 32'd0 : model_mem[in_addr[9:2]];
      end
      exp_q.push_back(e);
    end
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected_result: got tag %0d, expected no result", res_tag);
      end else begin
        e = exp_q.pop_front();
        chk("sb_tag",   {27'd0, res_tag}, {27'd0, e.tag});
        chk("sb_store", {31'd0, res_is_store}, {31'd0, e.st});
        chk("sb_data",  res_data, e.data);
        chk("sb_err",   {31'd0, res_err}, {31'd0, e.err});
      end
    end
  endtask

  task automatic step(input logic iv, input logic st, input logic [31:0] a, input logic [31:0] wd,
                      input logic [TAG_W-1:0] tg, input logic rr, input logic fl);
    @(negedge clk);
    in_valid = iv; in_is_store = st; in_addr = a; in_wr_data = wd; in_tag = tg;
    res_ready = rr; flush = fl;
    #1;
    sb_sample();
  endtask

  typedef struct {
    logic             iv, st;
    logic [31:0]      addr, wd;
    logic [TAG_W-1:0] tag;
    logic             rr;
    logic             e_rdy, e_qv, e_qw, e_qr;
    logic [31:0]      e_qa, e_qd;
    logic             e_rv;
    logic [TAG_W-1:0] e_rt;
    logic             e_rs;
    logic [31:0]      e_rd;
    logic [2:0]       e_cnt;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    for (int i = 0; i < 256; i++) model_mem[i] = preload(i);

    // store then dependent load, back to back
    tbl[0]  = '{1,1,32'h08,32'hDEADBEEF,3,1, 1,0,0,0,32'h0,32'h0,        0,0,0,32'h0,        0};
    tbl[1]  = '{1,0,32'h08,32'h0,4,1,        1,1,1,0,32'h8,32'hDEADBEEF, 0,0,0,32'h0,        1};
    tbl[2]  = '{0,0,32'h0,32'h0,0,1,         1,1,0,1,32'h8,32'h0,        1,3,1,32'h0,        1};
    tbl[3]  = '{0,0,32'h0,32'h0,0,1,         1,0,0,0,32'h0,32'h0,        1,4,0,32'hDEADBEEF, 0};
    tbl[4]  = '{0,0,32'h0,32'h0,0,1,         1,0,0,0,32'h0,32'h0,        0,0,0,32'h0,        0};
    // fill with result stalled, then drain in order
    tbl[5]  = '{1,0,32'h10,32'h0,10,0,       1,0,0,0,32'h0,32'h0,        0,0,0,32'h0,        0};
    tbl[6]  = '{1,0,32'h14,32'h0,11,0,       1,1,0,1,32'h10,32'h0,       0,0,0,32'h0,        1};
    tbl[7]  = '{1,0,32'h18,32'h0,12,0,       1,0,0,0,32'h0,32'h0,        1,10,0,preload(4),  1};
    tbl[8]  = '{1,0,32'h1C,32'h0,13,0,       1,0,0,0,32'h0,32'h0,        1,10,0,preload(4),  2};
    tbl[9]  = '{1,0,32'h20,32'h0,14,0,       1,0,0,0,32'h0,32'h0,        1,10,0,preload(4),  3};
    tbl[10] = '{1,0,32'h24,32'h0,15,0,       0,0,0,0,32'h0,32'h0,        1,10,0,preload(4),  4};
    tbl[11] = '{0,0,32'h0,32'h0,0,1,         0,1,0,1,32'h14,32'h0,       1,10,0,preload(4),  4};
    tbl[12] = '{0,0,32'h0,32'h0,0,1,         1,1,0,1,32'h18,32'h0,       1,11,0,preload(5),  3};
    tbl[13] = '{0,0,32'h0,32'h0,0,1,         1,1,0,1,32'h1C,32'h0,       1,12,0,preload(6),  2};
    tbl[14] = '{0,0,32'h0,32'h0,0,1,         1,1,0,1,32'h20,32'h0,       1,13,0,preload(7),  1};
    tbl[15] = '{0,0,32'h0,32'h0,0,1,         1,0,0,0,32'h0,32'h0,        1,14,0,preload(8),  0};
    tbl[16] = '{0,0,32'h0,32'h0,0,1,         1,0,0,0,32'h0,32'h0,        0,0,0,32'h0,        0};

    // reset with in_valid asserted
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_req_valid", {31'd0, mif.mem_req.valid}, 32'd0);
    chk("rst_count",     {29'd0, count}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("post_rst_req_valid", {31'd0, mif.mem_req.valid}, 32'd0);
    chk("post_rst_count",     {29'd0, count}, 32'd0);
    chk("post_rst_res_valid", {31'd0, res_valid}, 32'd0);
    in_valid = 1'b0;

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].iv, tbl[i].st, tbl[i].addr, tbl[i].wd, tbl[i].tag, tbl[i].rr, 1'b0);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_count", i), {29'd0, count}, {29'd0, tbl[i].e_cnt});
      chk($sformatf("v%0d_req_valid", i), {31'd0, mif.mem_req.valid}, {31'd0, tbl[i].e_qv});
      chk($sformatf("v%0d_req_write", i), {31'd0, mif.mem_req.MemWrite}, {31'd0, tbl[i].e_qw});
      chk($sformatf("v%0d_req_read", i), {31'd0, mif.mem_req.MemRead}, {31'd0, tbl[i].e_qr});
      chk($sformatf("v%0d_req_addr", i), mif.mem_req.addr, tbl[i].e_qa);
      chk($sformatf("v%0d_req_wdata", i), mif.mem_req.wr_data, tbl[i].e_qd);
      chk($sformatf("v%0d_res_valid", i), {31'd0, res_valid}, {31'd0, tbl[i].e_rv});
      if (tbl[i].e_rv) begin
        chk($sformatf("v%0d_res_tag", i), {27'd0, res_tag}, {27'd0, tbl[i].e_rt});
        chk($sformatf("v%0d_res_store", i), {31'd0, res_is_store}, {31'd0, tbl[i].e_rs});
        chk($sformatf("v%0d_res_data", i), res_data, tbl[i].e_rd);
        chk($sformatf("v%0d_res_err", i), {31'd0, res_err}, 32'd0);
      end
    end

    // flush while the head is a store: the store must never reach memory
    step(1, 0, 32'h44, 32'h0, 19, 0, 0);
    step(1, 1, 32'h40, 32'h12345678, 20, 0, 0);
    step(1, 0, 32'h48, 32'h0, 21, 0, 0);
    step(1, 0, 32'h4C, 32'h0, 22, 0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 1, 1);
    chk("flush_pre_count",  {29'd0, count}, 32'd3);
    chk("flush_req_valid",  {31'd0, mif.mem_req.valid}, 32'd0);
    chk("flush_req_write",  {31'd0, mif.mem_req.MemWrite}, 32'd0);
    chk("flush_in_ready",   {31'd0, in_ready}, 32'd0);
    step(0, 0, 32'h0, 32'h0, 0, 1, 0);
    chk("flush_post_count",     {29'd0, count}, 32'd0);
    chk("flush_post_res_valid", {31'd0, res_valid}, 32'd0);
    chk("flush_post_req_valid", {31'd0, mif.mem_req.valid}, 32'd0);
    step(1, 0, 32'h40, 32'h0, 23, 1, 0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step(0, 0, 32'h0, 32'h0, 0, 1, 0);
      if (res_valid) got = 1'b1;
    end
    chk("flush_reload_seen", {31'd0, got}, 32'd1);
    chk("flush_reload_tag",  {27'd0, res_tag}, 32'd23);
    chk("flush_reload_data", res_data, preload(16));
    step(0, 0, 32'h0, 32'h0, 0, 1, 0);

    // streaming past pointer wrap, one op per cycle
    sb_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(i < 10, (i % 2) == 0, 32'h80 + 32'(4 * (i / 2)), 32'hC0DE_0000 + 32'(i), 5'(i), 1, 0);
      if (i >= 1 && i <= 10) chk($sformatf("wrap_c%0d_count", i), {29'd0, count}, 32'd1);
      if (i >= 2) chk($sformatf("wrap_c%0d_res_valid", i), {31'd0, res_valid}, 32'd1);
    end
    step(0, 0, 32'h0, 32'h0, 0, 1, 0);
    chk("wrap_all_returned", exp_q.size(), 32'd0);
    sb_on = 1'b0;

    // misaligned load
    step(1, 0, 32'h05, 32'h0, 7, 1, 0);
    step(0, 0, 32'h0, 32'h0, 0, 1, 0);
`ifdef MISALIGN_TRAP_EN
    chk("mis_req_valid", {31'd0, mif.mem_req.valid}, 32'd0);
    chk("mis_req_read",  {31'd0, mif.mem_req.MemRead}, 32'd0);
`else
    chk("mis_req_valid", {31'd0, mif.mem_req.valid}, 32'd1);
    chk("mis_req_read",  {31'd0, mif.mem_req.MemRead}, 32'd1);
    chk("mis_req_addr",  mif.mem_req.addr, 32'h05);
`endif
    step(0, 0, 32'h0, 32'h0, 0, 1, 0);
    chk("mis_res_valid", {31'd0, res_valid}, 32'd1);
    chk("mis_res_tag",   {27'd0, res_tag}, 32'd7);
`ifdef MISALIGN_TRAP_EN
    chk("mis_res_err",   {31'd0, res_err}, 32'd1);
    chk("mis_res_data",  res_data, 32'd0);
`else
    chk("mis_res_err",   {31'd0, res_err}, 32'd0);
    chk("mis_res_data",  res_data, preload(1));
`endif
    step(0, 0, 32'h0, 32'h0, 0, 1, 0);

    // random traffic on a private address window
    sb_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic [31:0] a;
      logic [1:0]  lo;
      lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      a  = 32'h100 | (32'($urandom_range(0, 15)) << 2) | {30'd0, lo};
      step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), a, $urandom, 5'(c),
           $urandom_range(0, 9) < 6, 0);
      if (count > 3'(DEPTH)) chk("rand_count_bound", {29'd0, count}, DEPTH);
    end
    for (int c = 0; c < 50 && (exp_q.size() != 0 || count != 0 || res_valid); c++)
      step(0, 0, 32'h0, 32'h0, 0, 1, 0);
    chk("rand_drain_model", exp_q.size(), 32'd0);
    chk("rand_drain_count", {29'd0, count}, 32'd0);
    sb_on = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
